// File: rtl/vga_pingpong_fb_if.sv
`default_nettype none
// ============================================================================
// vga_pingpong_fb_if : writer-side pixel write port and swap handshake
// Rev 1.0
// ============================================================================
interface vga_pingpong_fb_if #(
  parameter int PIXEL_W = 3,
  parameter int H_RES   = 16,
  parameter int V_RES   = 12,
  parameter int XW      = $clog2(H_RES),
  parameter int YW      = $clog2(V_RES)
);
  logic               wr_en;
  logic [XW-1:0]      wr_x;
  logic [YW-1:0]      wr_y;
  logic [PIXEL_W-1:0] wr_data;
  logic               wr_ready;
  logic               swap_req;
  logic               swap_ack;

  modport master (
    output wr_en, wr_x, wr_y, wr_data, swap_req,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, swap_req,
    output wr_ready, swap_ack
  );
endinterface
`default_nettype wire

// File: rtl/vga_pingpong_fb.sv
`default_nettype none
// ============================================================================
// vga_pingpong_fb : ping-pong frame buffer, swap taken only at frame end.
// Optional back-buffer clear after each swap: VGA_FB_CLEAR_ON_SWAP_EN
// Rev 1.0
// ============================================================================
module vga_pingpong_fb #(
  parameter int PIXEL_W = 3,
  parameter int H_RES   = 16,
  parameter int V_RES   = 12,
  parameter int XW      = $clog2(H_RES),
  parameter int YW      = $clog2(V_RES)
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic         pix_ce,
  output logic [PIXEL_W-1:0] pixel,
  output logic              pix_valid,
  output logic [XW-1:0]     scan_x,
  output logic [YW-1:0]     scan_y,
  output logic              frame_start,
  output logic              front_sel,
  vga_pingpong_fb_if.slave  wr_bus
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_PENDING = 2'd1;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
  localparam logic [1:0] C_CLEAR   = 2'd2;
`endif

  logic [PIXEL_W-1:0] r_mem [2][DEPTH];
  logic [XW-1:0]      r_scan_x;
  logic [YW-1:0]      r_scan_y;
  logic [PIXEL_W-1:0] r_pixel;
  logic               r_pix_valid;
  logic               r_frame_start;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_front_sel;
  logic               r_swap_taken;
  logic               r_swap_ack;
  logic               w_wr_ready;
  logic               w_swap_take;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_frame_end;
  logic               w_wr_in_range;
  logic               w_wr_fire;
  logic [AW-1:0]      w_rd_addr;
  logic [AW-1:0]      w_wr_addr;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
  logic [AW-1:0]      r_clr_addr;
  logic               w_clearing;
  logic               w_clr_last;
`endif

  assign w_x_last      = (r_scan_x == XW'(H_RES - 1));
  assign w_y_last      = (r_scan_y == YW'(V_RES - 1));
  assign w_frame_end   = pix_ce && w_x_last && w_y_last;
  assign w_rd_addr     = AW'(int'(r_scan_y) * H_RES + int'(r_scan_x));
  assign w_wr_addr     = AW'(int'(wr_bus.wr_y) * H_RES + int'(wr_bus.wr_x));
  assign w_wr_in_range = (int'(wr_bus.wr_x) < H_RES) && (int'(wr_bus.wr_y) < V_RES);
  assign w_wr_fire     = wr_bus.wr_en && w_wr_ready && w_wr_in_range;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
  assign w_clr_last    = (r_clr_addr == AW'(DEPTH - 1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scan_x      <= '0;
      r_scan_y      <= '0;
      r_pixel       <= '0;
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_valid   <= pix_ce;
      r_frame_start <= pix_ce && (r_scan_x == '0) && (r_scan_y == '0);
      if (pix_ce) begin
        r_pixel <= r_mem[r_front_sel][w_rd_addr];
        if (w_x_last) begin
          r_scan_x <= '0;
          r_scan_y <= w_y_last ? '0 : r_scan_y + 1'b1;
        end else begin
          r_scan_x <= r_scan_x + 1'b1;
        end
      end
    end
  end

  // Only the back buffer (~front) is ever written, by the port or the clear engine.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[0][i] <= '0;
        r_mem[1][i] <= '0;
      end
    end else begin
      if (w_wr_fire)
        r_mem[~r_front_sel][w_wr_addr] <= wr_bus.wr_data;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
      if (w_clearing)
        r_mem[~r_front_sel][r_clr_addr] <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= C_IDLE;
      r_front_sel  <= 1'b0;
      r_swap_taken <= 1'b0;
      r_swap_ack   <= 1'b0;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
      r_clr_addr   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_swap_taken <= w_swap_take;
      r_swap_ack   <= r_swap_taken;
      if (w_swap_take)
        r_front_sel <= ~r_front_sel;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
      if (w_clearing)
        r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
`endif
    end
  end

  // A request still held across the swap and ack cycles belongs to the old swap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:
        if (wr_bus.swap_req && !r_swap_taken && !r_swap_ack)
          w_state_nxt = C_PENDING;
      C_PENDING:
        if (w_frame_end)
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
          w_state_nxt = C_CLEAR;
      C_CLEAR:
        if (w_clr_last)
          w_state_nxt = C_IDLE;
`else
          w_state_nxt = C_IDLE;
`endif
      default:
        w_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    w_wr_ready  = 1'b0;
    w_swap_take = 1'b0;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
    w_clearing  = 1'b0;
`endif
    case (r_state)
      C_IDLE:    w_wr_ready  = 1'b1;
      C_PENDING: w_swap_take = w_frame_end;
`ifdef VGA_FB_CLEAR_ON_SWAP_EN
      C_CLEAR:   w_clearing  = 1'b1;
`endif
      default:   w_wr_ready  = 1'b0;
    endcase
  end

  assign pixel           = r_pixel;
  assign pix_valid       = r_pix_valid;
  assign scan_x          = r_scan_x;
  assign scan_y          = r_scan_y;
  assign frame_start     = r_frame_start;
  assign front_sel       = r_front_sel;
  assign wr_bus.wr_ready = w_wr_ready;
  assign wr_bus.swap_ack = r_swap_ack;
endmodule
`default_nettype wire
